// File: rtl/sdram_ex_pkg.sv
// Shared types and constants for the SDRAM example pattern driver.
// Holds the FSM state enum, LFSR taps, error counter width and the lane step function.
package sdram_ex_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StRead,
      StDrain
   } drv_state_e;

   // Galois feedback mask for x^8+x^4+x^3+x^2+1
   localparam logic [7:0] LfsrTaps = 8'h1D;

   localparam int unsigned ErrCountW = 16;

   function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
      return {cur[6:0], 1'b0} ^ (cur[7] ? LfsrTaps : 8'h00);
   endfunction

endpackage

// File: rtl/sdram_ex_pattern_lfsr.sv
// One 8-bit Galois LFSR lane: reloads its seed on load, advances one step on step.
module sdram_ex_pattern_lfsr
   import sdram_ex_pkg::*;
#(
   parameter logic [7:0] SEED = 8'h01
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       step,
   output logic [7:0] value
);

   logic [7:0] value_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= SEED;
      end else if (load) begin
         value_q <= SEED;
      end else if (step) begin
         value_q <= lfsr_step(value_q);
      end
   end

   assign value = value_q;

endmodule

// File: rtl/sdram_ex_pattern_driver.sv
// Self-test sequencer: writes NUM_WORDS LFSR words from BASE_ADDR over Avalon-MM, reads them back
// and compares. Define SDRAM_EX_ERR_CAPTURE_EN to add first-mismatch capture outputs.
module sdram_ex_pattern_driver
   import sdram_ex_pkg::*;
#(
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned LANES     = 2,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned NUM_WORDS = 256,
   parameter int unsigned MAX_PEND  = 8,
   parameter int unsigned SEED      = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ErrCountW-1:0] err_count,
`ifdef SDRAM_EX_ERR_CAPTURE_EN
   output logic [ADDR_W-1:0]    err_addr,
   output logic [8*LANES-1:0]   err_expected,
   output logic [8*LANES-1:0]   err_actual,
`endif
   output logic [ADDR_W-1:0]    avm_address,
   output logic                 avm_write,
   output logic [8*LANES-1:0]   avm_writedata,
   output logic [LANES-1:0]     avm_byteenable,
   output logic                 avm_read,
   input  logic                 avm_waitrequest,
   input  logic [8*LANES-1:0]   avm_readdata,
   input  logic                 avm_readdatavalid
);

   localparam int unsigned DataW = 8 * LANES;
   localparam int unsigned CntW  = $clog2(NUM_WORDS + 1);
   localparam int unsigned PendW = $clog2(MAX_PEND + 1);
   localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
   localparam logic [CntW-1:0]   LastWord = CntW'(NUM_WORDS - 1);
   localparam logic [CntW-1:0]   AllWords = CntW'(NUM_WORDS);
   localparam logic [PendW-1:0]  PendMax  = PendW'(MAX_PEND);

   drv_state_e           state_q, state_d;
   logic [ADDR_W-1:0]    addr_q;
   logic [CntW-1:0]      word_cnt_q;
   logic [CntW-1:0]      rcv_cnt_q;
   logic [PendW-1:0]     pend_q;
   logic [ErrCountW-1:0] err_cnt_q;
   logic                 done_q;
   logic                 pass_q;
   logic [DataW-1:0]     gen_data;
   logic [DataW-1:0]     chk_data;

   logic start_acc, wr_acc, rd_acc, rtn, mismatch;
   logic last_wr, last_rd, drained, lfsr_load;

   assign start_acc = (state_q == StIdle) & start;
   assign wr_acc    = avm_write & ~avm_waitrequest;
   assign rd_acc    = avm_read & ~avm_waitrequest;
   // Returns only count while a read phase is live; stale ones after reset fall on the floor
   assign rtn       = avm_readdatavalid & ((state_q == StRead) | (state_q == StDrain));
   assign mismatch  = rtn & (avm_readdata != chk_data);
   assign last_wr   = wr_acc & (word_cnt_q == LastWord);
   assign last_rd   = rd_acc & (word_cnt_q == LastWord);
   assign drained   = (pend_q == '0) & (rcv_cnt_q == AllWords);
   assign lfsr_load = (state_q == StIdle);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start)   state_d = StWrite;
         StWrite: if (last_wr) state_d = StRead;
         StRead:  if (last_rd) state_d = StDrain;
         StDrain: if (drained) state_d = StIdle;
      endcase
   end

   // Read throttle looks only at registered pending, so it can never drop mid-stall
   always_comb begin
      busy      = (state_q != StIdle);
      avm_write = (state_q == StWrite);
      avm_read  = (state_q == StRead) & (pend_q < PendMax);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q     <= '0;
         word_cnt_q <= '0;
         rcv_cnt_q  <= '0;
         pend_q     <= '0;
         err_cnt_q  <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         if (start_acc) begin
            addr_q     <= BaseAddr;
            word_cnt_q <= '0;
            rcv_cnt_q  <= '0;
            pend_q     <= '0;
            err_cnt_q  <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
         end
         if (wr_acc) begin
            addr_q     <= last_wr ? BaseAddr : addr_q + 1'b1;
            word_cnt_q <= last_wr ? '0 : word_cnt_q + 1'b1;
         end
         if (rd_acc) begin
            addr_q     <= addr_q + 1'b1;
            word_cnt_q <= word_cnt_q + 1'b1;
         end
         if (rd_acc & ~rtn) begin
            pend_q <= pend_q + 1'b1;
         end else if (rtn & ~rd_acc & (pend_q != '0)) begin
            pend_q <= pend_q - 1'b1;
         end
         if (rtn) begin
            rcv_cnt_q <= rcv_cnt_q + 1'b1;
         end
         if (mismatch & (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
         end
         if ((state_q == StDrain) & drained) begin
            done_q <= 1'b1;
            pass_q <= (err_cnt_q == '0);
         end
      end
   end

   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_cnt_q;
   assign avm_address    = addr_q;
   assign avm_byteenable = '1;
   assign avm_writedata  = avm_write ? gen_data : '0;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam logic [7:0] LaneSeed = 8'((SEED + i) % 256);

      sdram_ex_pattern_lfsr #(
         .SEED (LaneSeed)
      ) u_gen (
         .clk   (clk),
         .reset (reset),
         .load  (lfsr_load),
         .step  (wr_acc),
         .value (gen_data[8*i +: 8])
      );

      sdram_ex_pattern_lfsr #(
         .SEED (LaneSeed)
      ) u_chk (
         .clk   (clk),
         .reset (reset),
         .load  (lfsr_load),
         .step  (rtn),
         .value (chk_data[8*i +: 8])
      );
   end

`ifdef SDRAM_EX_ERR_CAPTURE_EN
   logic [ADDR_W-1:0] rcv_addr_q;
   logic              err_seen_q;
   logic [ADDR_W-1:0] err_addr_q;
   logic [DataW-1:0]  err_exp_q;
   logic [DataW-1:0]  err_act_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rcv_addr_q <= '0;
         err_seen_q <= 1'b0;
         err_addr_q <= '0;
         err_exp_q  <= '0;
         err_act_q  <= '0;
      end else if (start_acc) begin
         rcv_addr_q <= BaseAddr;
         err_seen_q <= 1'b0;
         err_addr_q <= '0;
         err_exp_q  <= '0;
         err_act_q  <= '0;
      end else begin
         if (rtn) begin
            rcv_addr_q <= rcv_addr_q + 1'b1;
         end
         if (mismatch & ~err_seen_q) begin
            err_seen_q <= 1'b1;
            err_addr_q <= rcv_addr_q;
            err_exp_q  <= chk_data;
            err_act_q  <= avm_readdata;
         end
      end
   end

   assign err_addr     = err_addr_q;
   assign err_expected = err_exp_q;
   assign err_actual   = err_act_q;
`endif

endmodule

// File: tb/tb_sdram_ex_pattern_driver.sv
// Bench for sdram_ex_pattern_driver: Avalon memory model with stalls, latency and corruption,
// checked against an arithmetic LFSR reference. Capture checks follow SDRAM_EX_ERR_CAPTURE_EN.
module tb_sdram_ex_pattern_driver;

   localparam int unsigned ADDR_W    = 24;
   localparam int unsigned LANES     = 2;
   localparam int unsigned BASE_ADDR = 32'h00FF_FFF8;
   localparam int unsigned NUM_WORDS = 16;
   localparam int unsigned MAX_PEND  = 8;
   localparam int unsigned SEED      = 32;
   localparam int unsigned DW        = 8 * LANES;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              busy, done, pass;
   logic [15:0]       err_count;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_write, avm_read;
   logic [DW-1:0]     avm_writedata;
   logic [LANES-1:0]  avm_byteenable;
   logic              avm_waitrequest = 1'b0;
   logic [DW-1:0]     avm_readdata = '0;
   logic              avm_readdatavalid = 1'b0;
`ifdef SDRAM_EX_ERR_CAPTURE_EN
   logic [ADDR_W-1:0] err_addr;
   logic [DW-1:0]     err_expected, err_actual;
`endif

   always #5 clk = ~clk;

   sdram_ex_pattern_driver #(
      .ADDR_W    (ADDR_W),
      .LANES     (LANES),
      .BASE_ADDR (BASE_ADDR),
      .NUM_WORDS (NUM_WORDS),
      .MAX_PEND  (MAX_PEND),
      .SEED      (SEED)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .busy              (busy),
      .done              (done),
      .pass              (pass),
      .err_count         (err_count),
`ifdef SDRAM_EX_ERR_CAPTURE_EN
      .err_addr          (err_addr),
      .err_expected      (err_expected),
      .err_actual        (err_actual),
`endif
      .avm_address       (avm_address),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: lane value after n steps, straight from the bit equations
   function automatic logic [7:0] lane_val(input int lane, input int n);
      logic [7:0] o, x;
      o = 8'((SEED + lane) % 256);
      for (int k = 0; k < n; k++) begin
         x[0]   = o[7];
         x[1]   = o[0];
         x[2]   = o[1] ^ o[7];
         x[3]   = o[2] ^ o[7];
         x[4]   = o[3] ^ o[7];
         x[7:5] = o[6:4];
         o      = x;
      end
      return o;
   endfunction

   function automatic logic [DW-1:0] exp_word(input int n);
      return {lane_val(1, n), lane_val(0, n)};
   endfunction

   function automatic logic [ADDR_W-1:0] exp_addr(input int n);
      return ADDR_W'(BASE_ADDR + n);
   endfunction

   typedef struct {
      int          stall_mode;   // 0 none, 1 random, 2 three cycles on the 2nd write
      int          stall_pct;
      int          lat_min;
      int          lat_max;
      logic [15:0] corrupt;      // word indices whose bit 0 is flipped on return
      bit          pulse_busy;
      bit          chk_max;
      int          exp_err;
      bit          exp_pass;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } rtn_t;

   int            cyc = 0;
   int            wr_idx = 0, rd_idx = 0, pend = 0, stale = 0, max_pend_seen = 0;
   int            stall_mode = 0, stall_pct = 0, stall_left = 0, lat_min = 1, lat_max = 1;
   int            lat;
   logic [15:0]   corrupt = '0;
   logic [7:0]    wr_lo [16];
   rtn_t          rq[$];
   rtn_t          r;
   logic [DW-1:0] mem [logic [ADDR_W-1:0]];
   logic [DW-1:0] d;
   logic          prev_wr_stall = 1'b0, prev_rd_stall = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;
   logic [DW-1:0]     prev_data = '0;

   // Slave model: outputs are registered-only, so sampling at negedge predicts the next edge
   always @(negedge clk) begin
      cyc++;
      avm_waitrequest = 1'b0;
      if (stall_mode == 1) begin
         avm_waitrequest = ($urandom_range(99) < stall_pct);
      end else if (stall_mode == 2 && avm_write && wr_idx == 1 && stall_left > 0) begin
         avm_waitrequest = 1'b1;
         stall_left--;
      end
      if (pend >= int'(MAX_PEND)) chk("no_read_at_max_pend", avm_read, 0);
      if (prev_wr_stall) begin
         chk("wr_hold", avm_write, 1);
         chk("wr_addr_hold", avm_address, prev_addr);
         chk("wr_data_hold", avm_writedata, prev_data);
      end
      if (prev_rd_stall) begin
         chk("rd_hold", avm_read, 1);
         chk("rd_addr_hold", avm_address, prev_addr);
      end
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         r = rq.pop_front();
         avm_readdatavalid = 1'b1;
         avm_readdata      = r.data;
         if (stale > 0) stale--;
         else if (pend > 0) pend--;
      end
      if (!reset && avm_write && !avm_waitrequest) begin
         chk("wr_addr", avm_address, exp_addr(wr_idx));
         chk("wr_data", avm_writedata, exp_word(wr_idx));
         mem[avm_address] = avm_writedata;
         if (wr_idx < 16) wr_lo[wr_idx] = avm_writedata[7:0];
         wr_idx++;
      end
      if (!reset && avm_read && !avm_waitrequest) begin
         chk("rd_addr", avm_address, exp_addr(rd_idx));
         d = mem.exists(avm_address) ? mem[avm_address] : '0;
         if (rd_idx < 16 && corrupt[rd_idx]) d = d ^ 1;
         lat = int'($urandom_range(lat_max, lat_min));
         rq.push_back('{d, cyc + lat});
         rd_idx++;
         pend++;
      end
      if (pend > max_pend_seen) max_pend_seen = pend;
      prev_wr_stall = avm_write && avm_waitrequest && !reset;
      prev_rd_stall = avm_read && avm_waitrequest && !reset;
      prev_addr     = avm_address;
      prev_data     = avm_writedata;
      if (reset) begin
         pend  = 0;
         stale = rq.size();
      end
   end

   task automatic run_pass(input vec_t v, input string tag);
      int first;
      stall_mode    = v.stall_mode;
      stall_pct     = v.stall_pct;
      stall_left    = 3;
      lat_min       = v.lat_min;
      lat_max       = v.lat_max;
      corrupt       = v.corrupt;
      wr_idx        = 0;
      rd_idx        = 0;
      max_pend_seen = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_start_busy"}, busy, 1);
      chk({tag, "_start_write"}, avm_write, 1);
      chk({tag, "_start_addr"}, avm_address, exp_addr(0));
      chk({tag, "_start_done_clr"}, done, 0);
      chk({tag, "_start_err_clr"}, err_count, 0);
      if (v.pulse_busy) begin
         repeat (6) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int t = 0; t < 4000 && done !== 1'b1; t++) @(negedge clk);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_pass"}, pass, v.exp_pass);
      chk({tag, "_err_count"}, err_count, v.exp_err);
      chk({tag, "_busy_clear"}, busy, 0);
      chk({tag, "_writes"}, wr_idx, NUM_WORDS);
      chk({tag, "_reads"}, rd_idx, NUM_WORDS);
      repeat (30) @(negedge clk);
      chk({tag, "_still_idle"}, busy, 0);
      chk({tag, "_no_rerun"}, wr_idx, NUM_WORDS);
      chk({tag, "_done_level"}, done, 1);
      chk({tag, "_returns_drained"}, rq.size(), 0);
      if (v.chk_max) chk({tag, "_pend_reached_max"}, max_pend_seen, MAX_PEND);
`ifdef SDRAM_EX_ERR_CAPTURE_EN
      first = -1;
      for (int i = 15; i >= 0; i--) if (v.corrupt[i]) first = i;
      if (first >= 0) begin
         chk({tag, "_err_addr"}, err_addr, exp_addr(first));
         chk({tag, "_err_expected"}, err_expected, exp_word(first));
         chk({tag, "_err_actual"}, err_actual, exp_word(first) ^ 1);
      end else begin
         chk({tag, "_err_addr_clear"}, err_addr, 0);
      end
`else
      first = 0;
`endif
   endtask

   vec_t       tbl[6];
   vec_t       clean;
   logic [7:0] seq4 [4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, 0, 1, 1, 16'h0000, 1'b0, 1'b0, 0, 1'b1};
      tbl[1] = '{0, 0, 1, 1, 16'h0020, 1'b0, 1'b0, 1, 1'b0};
      tbl[2] = '{2, 0, 1, 1, 16'h0000, 1'b0, 1'b0, 0, 1'b1};
      tbl[3] = '{0, 0, 20, 20, 16'h0000, 1'b0, 1'b1, 0, 1'b1};
      tbl[4] = '{1, 30, 2, 6, 16'h8009, 1'b1, 1'b0, 3, 1'b0};
      tbl[5] = '{1, 50, 1, 9, 16'hFFFF, 1'b0, 1'b0, 16, 1'b0};
      clean  = '{1, 20, 1, 4, 16'h0000, 1'b0, 1'b0, 0, 1'b1};
      seq4   = '{8'h20, 8'h40, 8'h80, 8'h1D};

      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_write", avm_write, 0);
      chk("rst_read", avm_read, 0);
      chk("rst_address", avm_address, 0);
      chk("rst_writedata", avm_writedata, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_pass(tbl[i], $sformatf("v%0d", i));
         if (i == 0) begin
            for (int k = 0; k < 4; k++) chk($sformatf("lane0_seq%0d", k), wr_lo[k], seq4[k]);
         end
      end

      // Abort during the read phase, then a fresh pass must be clean
      stall_mode = 0;
      lat_min    = 20;
      lat_max    = 20;
      corrupt    = '0;
      wr_idx     = 0;
      rd_idx     = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t < 500 && avm_read !== 1'b1; t++) @(negedge clk);
      chk("abort_reached_read", avm_read, 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_read", avm_read, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int t = 0; t < 500 && rq.size() != 0; t++) @(negedge clk);
      chk("abort_stale_drained", rq.size(), 0);
      chk("abort_still_idle", busy, 0);
      run_pass(clean, "after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
